pixel_write_scheduler: RTL
==========================

// Module: pixel_write_scheduler
// PURPOSE
//  Shares one framebuffer write port between NUM_REQ pixel producers (sprite/shape drawers).
//  Each producer offers (x, y, rgb) pixels over valid/ready; the block arbitrates round-robin,
//  bounds-checks coordinates, converts (x, y) to a linear address and issues one write per cycle.
//  Sits between the pixel-processing stage and the screen memory that feeds the display scan-out.
// PARAMETERS
//  NUM_REQ   2     number of pixel requesters (>=2)
//  SCREEN_W  640   visible width in pixels
//  SCREEN_H  480   visible height in pixels
//  XW        10    x coordinate width
//  YW        9     y coordinate width
//  AW        19    framebuffer address width (>= clog2(SCREEN_W*SCREEN_H))
// PORTS
//  clk         in   1           system clock, all logic on rising edge
//  reset       in   1           synchronous, active-high reset
//  req_valid   in   NUM_REQ     requester i offers a pixel
//  req_ready   out  NUM_REQ     one-hot grant; pixel i accepted when valid[i]&ready[i]
//  req_x       in   NUM_REQ*XW  packed x coords, requester i at [i*XW +: XW]
//  req_y       in   NUM_REQ*YW  packed y coords
//  req_rgb     in   NUM_REQ*24  packed {red,green,blue}, 8 bits each
//  fb_we       out  1           framebuffer write strobe
//  fb_addr     out  AW          linear address y*SCREEN_W + x
//  fb_data     out  24          {red,green,blue}
//  drop_count  out  16          count of rejected out-of-range pixels, saturating
//  busy        out  1           clear sweep in progress (0 when clear feature compiled out)
//  clear_start in   1           [PIXEL_SCHED_CLEAR_EN only] pulse: start full-screen clear
//  clear_rgb   in   24          [PIXEL_SCHED_CLEAR_EN only] colour written by the clear sweep
// BEHAVIOUR
//  - Reset: fb_we=0, fb_addr=0, fb_data=0, drop_count=0, busy=0, req_ready=0, rr pointer=0, state=ARB.
//  - States: ARB (normal), CLEAR (compiled in only). No other states.
//  - ARB: grant = first valid index scanning ptr, ptr+1, ... mod NUM_REQ; req_ready combinational
//    one-hot of grant, all-zero when no valid or when not in ARB. Zero-bubble: a new grant every cycle.
//  - On handshake, ptr <= (grant+1) mod NUM_REQ; with no handshake, ptr holds.
//  - Latency 1: pixel accepted in cycle n -> fb_we/fb_addr/fb_data registered and valid in cycle n+1.
//    fb_we is high one cycle per accepted in-range pixel; fb_addr/fb_data hold last value when fb_we=0.
//  - Bounds: x>=SCREEN_W or y>=SCREEN_H -> pixel is still consumed (ready=1), no write issued,
//    drop_count+1, saturating at 16'hFFFF.
//  - Address arithmetic: y*SCREEN_W + x computed at AW bits, no truncation for in-range pixels.
//  - Requesters must hold x/y/rgb stable while valid && !ready; de-asserting valid early is allowed.
// CONFIGURATION
//  - Macro PIXEL_SCHED_CLEAR_EN defined: clear_start/clear_rgb ports exist. clear_start in ARB ->
//    CLEAR next cycle; clear wins over any same-cycle request (no ready issued that cycle).
//    CLEAR writes clear_rgb (sampled at start) to addr 0..SCREEN_W*SCREEN_H-1, one per cycle,
//    fb_we=1 throughout, req_ready=0, busy=1; returns to ARB after final address; clear_start
//    during CLEAR ignored. Reset mid-sweep aborts: fb_we=0 next cycle, state ARB.
//  - Macro undefined: no clear ports, CLEAR state absent, busy tied 0.
// STRUCTURE
//  - Shared header pixel_defs.vh: SCREEN_W, SCREEN_H, XW, YW, AW, RGB_W=24, state encodings.
//  - Sub-module rr_arbiter (NUM_REQ valid -> one-hot grant, ptr update on accept); top holds
//    address compute, bounds check, output registers, drop counter, clear FSM.
// TESTING
//  1. Only req0: x=3,y=2,rgb=24'h55F00F -> next cycle fb_we=1, fb_addr=1283, fb_data=24'h55F00F.
//  2. req0 and req1 valid continuously -> req_ready alternates 01,10,01,10; four writes in four cycles.
//  3. x=640,y=0 then x=0,y=480 -> ready=1 each, no fb_we, drop_count=1 then 2; preload saturation stays FFFF.
//  4. x=639,y=479 -> fb_addr=307199; x=0,y=0 -> fb_addr=0.
//  5. CLEAR_EN: clear_start with clear_rgb=0 and req0 valid -> 307200 writes addr 0..307199, busy=1,
//     req_ready=0; req0 granted the cycle after busy falls.
//  6. Reset asserted mid-clear and with valids held -> fb_we=0, ready=0 during reset; ptr=0 after.

Source files
------------

// File: rtl/pixel_write_scheduler_pkg.sv
// rtl/pixel_write_scheduler_pkg.sv - shared constants, state encoding and helpers
// Purpose: screen geometry, coordinate/address widths, colour width and FSM
//          state encoding shared by the scheduler, its arbiter and its interface.
// Ports:   none (package).
package pixel_write_scheduler_pkg;

   localparam int NUM_REQ_DEF  = 2;
   localparam int SCREEN_W_DEF = 640;
   localparam int SCREEN_H_DEF = 480;
   localparam int XW_DEF       = 10;
   localparam int YW_DEF       = 9;
   localparam int AW_DEF       = 19;
   localparam int RGB_W        = 24;
   localparam int DROP_W       = 16;

   typedef enum logic [0:0] {
      ST_ARB   = 1'b0,
      ST_CLEAR = 1'b1
   } state_t;

   // Pointer width for a round-robin over n requesters; never zero bits.
   function automatic int ptr_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/pixel_write_scheduler_if.sv
// rtl/pixel_write_scheduler_if.sv - pixel request and framebuffer write bundle
// Purpose: groups the per-requester valid/ready/x/y/rgb lanes and the
//          framebuffer write port.
// Ports:   req_valid/req_x/req_y/req_rgb  producer -> scheduler (packed per requester)
//          req_ready                      scheduler -> producer (one-hot grant)
//          fb_we/fb_addr/fb_data          scheduler -> framebuffer
// Modports: master (producer/memory side), slave (scheduler side).
interface pixel_write_scheduler_if
   import pixel_write_scheduler_pkg::*;
#(
   parameter int NUM_REQ = NUM_REQ_DEF,
   parameter int XW      = XW_DEF,
   parameter int YW      = YW_DEF,
   parameter int AW      = AW_DEF
) ();

   logic [NUM_REQ-1:0]       req_valid;
   logic [NUM_REQ-1:0]       req_ready;
   logic [NUM_REQ*XW-1:0]    req_x;
   logic [NUM_REQ*YW-1:0]    req_y;
   logic [NUM_REQ*RGB_W-1:0] req_rgb;
   logic                     fb_we;
   logic [AW-1:0]            fb_addr;
   logic [RGB_W-1:0]         fb_data;

   modport master (
      output req_valid, req_x, req_y, req_rgb,
      input  req_ready, fb_we, fb_addr, fb_data
   );

   modport slave (
      input  req_valid, req_x, req_y, req_rgb,
      output req_ready, fb_we, fb_addr, fb_data
   );

endinterface

// File: rtl/pixel_write_scheduler_rr_arbiter.sv
// rtl/pixel_write_scheduler_rr_arbiter.sv - round-robin one-hot grant generator
// Purpose: picks the first valid requester scanning from ptr upward (mod
//          NUM_REQ); a grant is an accept, so ptr moves past the winner.
// Ports:   clk, reset (sync, active high), enable (grant allowed this cycle),
//          valid[NUM_REQ] in, grant[NUM_REQ] one-hot out (combinational).
module pixel_write_scheduler_rr_arbiter
   import pixel_write_scheduler_pkg::*;
#(
   parameter int NUM_REQ = NUM_REQ_DEF
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               enable,
   input  logic [NUM_REQ-1:0] valid,
   output logic [NUM_REQ-1:0] grant
);

   localparam int PW = ptr_width(NUM_REQ);

   logic [PW-1:0] ptr;
   logic [PW-1:0] ptr_nx;

   always_comb begin
      int  idx;
      int  nxt;
      logic found;
      grant  = '0;
      ptr_nx = ptr;
      found  = 1'b0;
      idx    = 0;
      nxt    = 0;
      for (int i = 0; i < NUM_REQ; i++) begin
         idx = int'(ptr) + i;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         if (!found && enable && valid[idx]) begin
            found      = 1'b1;
            grant[idx] = 1'b1;
            nxt        = idx + 1;
            if (nxt >= NUM_REQ) nxt = 0;
            ptr_nx     = PW'(nxt);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) ptr <= '0;
      else       ptr <= ptr_nx;
   end

endmodule

// File: rtl/pixel_write_scheduler.sv
// rtl/pixel_write_scheduler.sv - shares one framebuffer write port among pixel producers
// Purpose: round-robin arbitration of NUM_REQ pixel producers, bounds check,
//          (x,y) -> y*SCREEN_W+x address, one registered write per cycle,
//          saturating count of out-of-range pixels. Optional full-screen clear
//          sweep when PIXEL_SCHED_CLEAR_EN is defined.
// Ports:   clk, reset (sync, active high)
//          bus         pixel_write_scheduler_if.slave (requests + framebuffer)
//          drop_count  saturating count of rejected pixels
//          busy        clear sweep in progress (tied 0 without PIXEL_SCHED_CLEAR_EN)
//          clear_start, clear_rgb  only with PIXEL_SCHED_CLEAR_EN
module pixel_write_scheduler
   import pixel_write_scheduler_pkg::*;
#(
   parameter int NUM_REQ  = NUM_REQ_DEF,
   parameter int SCREEN_W = SCREEN_W_DEF,
   parameter int SCREEN_H = SCREEN_H_DEF,
   parameter int XW       = XW_DEF,
   parameter int YW       = YW_DEF,
   parameter int AW       = AW_DEF
) (
   input  logic                  clk,
   input  logic                  reset,
   pixel_write_scheduler_if.slave bus,
   output logic [DROP_W-1:0]     drop_count,
   output logic                  busy
`ifdef PIXEL_SCHED_CLEAR_EN
   ,
   input  logic                  clear_start,
   input  logic [RGB_W-1:0]      clear_rgb
`endif
);

   logic [NUM_REQ-1:0] grant;
   logic               arb_en;
   logic               accept;
   logic               in_range;
   logic [XW-1:0]      sel_x;
   logic [YW-1:0]      sel_y;
   logic [RGB_W-1:0]   sel_rgb;
   logic [AW-1:0]      pix_addr;
   logic               fb_we_q;
   logic [AW-1:0]      fb_addr_q;
   logic [RGB_W-1:0]   fb_data_q;

`ifdef PIXEL_SCHED_CLEAR_EN
   localparam logic [AW-1:0] LAST_ADDR = AW'(SCREEN_W * SCREEN_H - 1);

   state_t           state;
   state_t           state_nx;
   logic [AW-1:0]    clr_addr;
   logic [RGB_W-1:0] clr_rgb_q;

   always_ff @(posedge clk) begin
      if (reset) state <= ST_ARB;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         ST_ARB:   if (clear_start) state_nx = ST_CLEAR;
         ST_CLEAR: if (clr_addr == LAST_ADDR) state_nx = ST_ARB;
         default:  state_nx = ST_ARB;
      endcase
   end

   // Sweep address restarts at 0 on every entry; colour is captured at start
   // so the caller may change clear_rgb while the sweep runs.
   always_ff @(posedge clk) begin
      if (reset) begin
         clr_addr  <= '0;
         clr_rgb_q <= '0;
      end else if (state == ST_ARB) begin
         clr_addr <= '0;
         if (clear_start) clr_rgb_q <= clear_rgb;
      end else begin
         clr_addr <= clr_addr + 1'b1;
      end
   end

   // A same-cycle clear_start wins over any pending request.
   assign arb_en = (state == ST_ARB) && !clear_start && !reset;
   assign busy   = (state == ST_CLEAR);
`else
   assign arb_en = !reset;
   assign busy   = 1'b0;
`endif

   pixel_write_scheduler_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
      .clk    (clk),
      .reset  (reset),
      .enable (arb_en),
      .valid  (bus.req_valid),
      .grant  (grant)
   );

   assign bus.req_ready = grant;
   assign accept        = |grant;

   always_comb begin
      sel_x   = '0;
      sel_y   = '0;
      sel_rgb = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant[i]) begin
            sel_x   = bus.req_x[i*XW +: XW];
            sel_y   = bus.req_y[i*YW +: YW];
            sel_rgb = bus.req_rgb[i*RGB_W +: RGB_W];
         end
      end
   end

   assign in_range = (int'(sel_x) < SCREEN_W) && (int'(sel_y) < SCREEN_H);
   assign pix_addr = AW'(sel_y) * AW'(SCREEN_W) + AW'(sel_x);

   // fb_addr/fb_data only change on a write so the memory side sees stable
   // values while fb_we is low.
   always_ff @(posedge clk) begin
      if (reset) begin
         fb_we_q    <= 1'b0;
         fb_addr_q  <= '0;
         fb_data_q  <= '0;
         drop_count <= '0;
      end else begin
         fb_we_q <= 1'b0;
`ifdef PIXEL_SCHED_CLEAR_EN
         if (state == ST_CLEAR) begin
            fb_we_q   <= 1'b1;
            fb_addr_q <= clr_addr;
            fb_data_q <= clr_rgb_q;
         end else
`endif
         if (accept && in_range) begin
            fb_we_q   <= 1'b1;
            fb_addr_q <= pix_addr;
            fb_data_q <= sel_rgb;
         end
         if (accept && !in_range && (drop_count != '1))
            drop_count <= drop_count + 1'b1;
      end
   end

   assign bus.fb_we   = fb_we_q;
   assign bus.fb_addr = fb_addr_q;
   assign bus.fb_data = fb_data_q;

endmodule
